// File: rtl/writeback_stage.sv
// writeback_stage: third stage of the NanoQuarter Minion pipeline.
// Buffers execute results in a 2-entry in-order queue and drains them into
// the register-file write port. It also tracks the architectural PC and a
// 16-bit count of retired entries.
// Optional feature: define WB_FWD_EN to enable forwarding lookup of pending
// register writes (fwd_hit/fwd_data). Without it those outputs are tied to 0.
module writeback_stage #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_regwrite,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              rf_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [PC_W-1:0]   pc_q,
  output logic [15:0]       retire_count,
  input  logic [REG_AW-1:0] fwd_rs,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);

  logic [DATA_W-1:0] r_data [2];
  logic              r_we   [2];
  logic [REG_AW-1:0] r_rd   [2];
  logic [PC_W-1:0]   r_pc   [2];

  logic              r_head;
  logic              r_tail;
  logic [1:0]        r_count;
  logic [PC_W-1:0]   r_pc_q;
  logic [15:0]       r_retire;

  logic              w_nonempty;
  logic              w_push;
  logic              w_pop;

  // in_ready depends only on the registered count, so rf_ready never reaches it
  assign in_ready   = (r_count != 2'd2);
  assign w_nonempty = (r_count != 2'd0);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = w_nonempty && (!r_we[r_head] || rf_ready);

  // Head presentation to the register-file port, zeroed when empty
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (w_nonempty) begin
      rf_we    = r_we[r_head];
      rf_waddr = r_rd[r_head];
      rf_wdata = r_data[r_head];
    end
  end

  // Entry storage; contents are qualified by the count, so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_tail] <= in_data;
      r_we[r_tail]   <= in_regwrite;
      r_rd[r_tail]   <= in_rd;
      r_pc[r_tail]   <= in_pc;
    end
  end

  // Pointers, occupancy and retirement state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_count  <= 2'd0;
      r_pc_q   <= '0;
      r_retire <= '0;
    end else begin
      if (w_push) r_tail <= ~r_tail;
      if (w_pop) begin
        r_head   <= ~r_head;
        r_pc_q   <= r_pc[r_head];
        r_retire <= r_retire + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign pc_q         = r_pc_q;
  assign retire_count = r_retire;

`ifdef WB_FWD_EN
  // Pending-write lookup; the younger entry (tail side) overrides the older one
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (w_nonempty && r_we[r_head] && (r_rd[r_head] == fwd_rs)) begin
      fwd_hit  = 1'b1;
      fwd_data = r_data[r_head];
    end
    if ((r_count == 2'd2) && r_we[~r_head] && (r_rd[~r_head] == fwd_rs)) begin
      fwd_hit  = 1'b1;
      fwd_data = r_data[~r_head];
    end
  end
`else
  logic w_unused_fwd_rs;
  assign w_unused_fwd_rs = ^fwd_rs;
  assign fwd_hit         = 1'b0;
  assign fwd_data        = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_regwrite = 1'b0;
  logic [2:0]  in_rd = '0;
  logic [31:0] in_pc = '0;
  logic        rf_ready = 1'b0;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [31:0] pc_q;
  logic [15:0] retire_count;
  logic [2:0]  fwd_rs = '0;
  logic        fwd_hit;
  logic [15:0] fwd_data;

  writeback_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_regwrite(in_regwrite), .in_rd(in_rd), .in_pc(in_pc),
    .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_q(pc_q), .retire_count(retire_count),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          c0;
  logic [18:0] wq[$];
  logic [31:0] pq[$];
  logic [15:0] prev_rc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one entry; returns at posedge+1 after it is accepted, in_valid left high
  task automatic send(input logic [15:0] d, input logic rw, input logic [2:0] rd,
                      input logic [31:0] pc);
    int n;
    in_valid = 1'b1; in_data = d; in_regwrite = rw; in_rd = rd; in_pc = pc;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 for rd=%0d", rd);
    end else begin
      @(posedge clk); #1;
      if (rw) wq.push_back({rd, d});
      pq.push_back(pc);
    end
  endtask

  // Monitor: compares every register-file write and every retirement
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_we && rf_ready) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_write: got write rd=%0d data=%0h expected none", rf_waddr, rf_wdata);
        end else begin
          chk("wb_write", {rf_waddr, rf_wdata}, wq.pop_front());
        end
      end
      if (retire_count != prev_rc) begin
        chk("retire_inc", retire_count, prev_rc + 16'd1);
        if (pq.size() == 0) begin
          checks++; errors++;
          $display("FAIL retire_pc: got retire pc=%0h expected none", pc_q);
        end else begin
          chk("retire_pc", pc_q, pq.pop_front());
        end
        prev_rc = retire_count;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_pc_q", pc_q, 0);
    chk("rst_retire", retire_count, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);

    // single write, one-cycle latency to the RF port
    rf_ready = 1'b1;
    send(16'hA5A5, 1'b1, 3'd3, 32'h10);
    chk("t1_rf_we", rf_we, 1);
    chk("t1_rf_waddr", rf_waddr, 3);
    chk("t1_rf_wdata", rf_wdata, 16'hA5A5);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t1_pc_q", pc_q, 32'h10);
    chk("t1_retire", retire_count, 1);
    chk("t1_rf_we_after", rf_we, 0);

    // back-pressure: two accepted, third stalls until RF drains
    rf_ready = 1'b0;
    send(16'h1111, 1'b1, 3'd1, 32'h14);
    send(16'h2222, 1'b1, 3'd2, 32'h18);
    chk("t2_full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_data = 16'h4444; in_regwrite = 1'b1; in_rd = 3'd4; in_pc = 32'h1C;
    repeat (2) begin @(posedge clk); #1; end
    chk("t2_stall_in_ready", in_ready, 0);
    chk("t2_held_waddr", rf_waddr, 1);
    chk("t2_held_we", rf_we, 1);
    rf_ready = 1'b1;
    send(16'h4444, 1'b1, 3'd4, 32'h1C);
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("t2_retire", retire_count, 4);
    chk("t2_drained", wq.size(), 0);

    // non-writing entry retires despite rf_ready=0
    rf_ready = 1'b0;
    send(16'hBEEF, 1'b0, 3'd7, 32'h40);
    chk("t3_rf_we", rf_we, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t3_pc_q", pc_q, 32'h40);
    chk("t3_retire", retire_count, 5);

    // full buffer then continuous stream with rf_ready=1
    send(16'hA001, 1'b1, 3'd1, 32'h100);
    send(16'hA002, 1'b0, 3'd2, 32'h104);
    chk("t4_full", in_ready, 0);
    rf_ready = 1'b1;
    c0 = cyc;
    send(16'hB001, 1'b1, 3'd3, 32'h108);
    send(16'hB002, 1'b0, 3'd4, 32'h10C);
    send(16'hB003, 1'b1, 3'd5, 32'h110);
    send(16'hB004, 1'b1, 3'd6, 32'h114);
    send(16'hB005, 1'b0, 3'd7, 32'h118);
    send(16'hB006, 1'b1, 3'd0, 32'h11C);
    chk("t4_cycles", cyc - c0, 7);
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("t4_wq_empty", wq.size(), 0);
    chk("t4_pq_empty", pq.size(), 0);
    chk("t4_retire", retire_count, 13);
    chk("t4_pc_q", pc_q, 32'h11C);

    // forwarding lookup with two pending writes to the same register
    rf_ready = 1'b0;
    send(16'h0011, 1'b1, 3'd5, 32'h200);
    send(16'h0022, 1'b1, 3'd5, 32'h204);
    in_valid = 1'b0;
    fwd_rs = 3'd5; #1;
`ifdef WB_FWD_EN
    chk("t5_fwd_hit", fwd_hit, 1);
    chk("t5_fwd_data", fwd_data, 16'h0022);
`else
    chk("t5_fwd_hit", fwd_hit, 0);
    chk("t5_fwd_data", fwd_data, 0);
`endif
    fwd_rs = 3'd6; #1;
    chk("t5_fwd_miss", fwd_hit, 0);
    chk("t5_fwd_miss_data", fwd_data, 0);

    // reset with two entries pending
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wq.delete(); pq.delete(); prev_rc = '0;
    chk("t6_in_ready", in_ready, 1);
    chk("t6_rf_we", rf_we, 0);
    chk("t6_rf_waddr", rf_waddr, 0);
    chk("t6_rf_wdata", rf_wdata, 0);
    chk("t6_pc_q", pc_q, 0);
    chk("t6_retire", retire_count, 0);
    fwd_rs = 3'd5; #1;
    chk("t6_fwd_hit", fwd_hit, 0);
    repeat (2) begin @(posedge clk); #1; end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
